// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: Moore FSM over one shared ALU and one unified memory port.
// 3-5 cycles per instruction; mem_ready=0 holds FETCH/MEMRD/MEMWR, adding one cycle per wait.
module mc_ctrl #(
    parameter int STATE_W = 4,
    parameter int RA_REG  = 31
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               EXTOp,
    output logic [4:0]         ALUOp,
    output logic [1:0]         PCSrc,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic [3:0]         LOADSel,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    if (RA_REG < 1 || RA_REG > 31 || STATE_W < 4) begin : g_bad_params
        $error("mc_ctrl: RA_REG must be 1..31 and STATE_W at least 4");
    end

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = STATE_W'(0),
        S_FETCH  = STATE_W'(1),
        S_DECODE = STATE_W'(2),
        S_MEMADR = STATE_W'(3),
        S_MEMRD  = STATE_W'(4),
        S_MEMWB  = STATE_W'(5),
        S_MEMWR  = STATE_W'(6),
        S_EXEC   = STATE_W'(7),
        S_ALUWB  = STATE_W'(8),
        S_BRANCH = STATE_W'(9),
        S_JUMP   = STATE_W'(10),
        S_JREG   = STATE_W'(11)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LB   = 6'h20, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_JR     = 6'h08, F_JALR  = 6'h09;

    localparam logic [4:0] ALU_ADD  = 5'd1,  ALU_SUB  = 5'd2,  ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4,  ALU_SLT  = 5'd5,  ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7,  ALU_NOR  = 5'd8,  ALU_LUI  = 5'd9;
    localparam logic [4:0] ALU_SRL  = 5'd10, ALU_SLLV = 5'd11, ALU_XOR  = 5'd12;
    localparam logic [4:0] ALU_SRA  = 5'd13, ALU_SRAV = 5'd14;

    state_t     state;
    logic [4:0] r_alu;
    logic [4:0] i_alu;
    logic       is_r_alu, is_i_alu, is_load, is_lb, is_sw;
    logic       is_branch, is_bne, is_jump, is_jal, is_jr, is_jalr, is_legal;

    // ALU op of an R-type function; 0 marks a function the datapath cannot execute
    always_comb begin
        r_alu = 5'd0;
        case (Funct)
            6'h20, 6'h21: r_alu = ALU_ADD;
            6'h22, 6'h23: r_alu = ALU_SUB;
            6'h24:        r_alu = ALU_AND;
            6'h25:        r_alu = ALU_OR;
            6'h26:        r_alu = ALU_XOR;
            6'h27:        r_alu = ALU_NOR;
            6'h2A:        r_alu = ALU_SLT;
            6'h2B:        r_alu = ALU_SLTU;
            6'h00:        r_alu = ALU_SLL;
            6'h02:        r_alu = ALU_SRL;
            6'h03:        r_alu = ALU_SRA;
            6'h04:        r_alu = ALU_SLLV;
            6'h07:        r_alu = ALU_SRAV;
            default:      r_alu = 5'd0;
        endcase
    end

    always_comb begin
        i_alu = 5'd0;
        case (Op)
            OP_ADDI: i_alu = ALU_ADD;
            OP_SLTI: i_alu = ALU_SLT;
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            OP_LUI:  i_alu = ALU_LUI;
            default: i_alu = 5'd0;
        endcase
    end

    assign is_r_alu  = (Op == OP_RTYPE) && (r_alu != 5'd0);
    assign is_i_alu  = (i_alu != 5'd0);
    assign is_lb     = (Op == OP_LB);
    assign is_load   = (Op == OP_LW) || is_lb;
    assign is_sw     = (Op == OP_SW);
    assign is_bne    = (Op == OP_BNE);
    assign is_branch = (Op == OP_BEQ) || is_bne;
    assign is_jal    = (Op == OP_JAL);
    assign is_jump   = (Op == OP_J) || is_jal;
    assign is_jr     = (Op == OP_RTYPE) && (Funct == F_JR);
    assign is_jalr   = (Op == OP_RTYPE) && (Funct == F_JALR);
    assign is_legal  = is_r_alu | is_i_alu | is_load | is_sw | is_branch | is_jump | is_jr | is_jalr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (is_load || is_sw)           state <= S_MEMADR;
                    else if (is_r_alu || is_i_alu)  state <= S_EXEC;
                    else if (is_branch)             state <= S_BRANCH;
                    else if (is_jump)               state <= S_JUMP;
                    else if (is_jr || is_jalr)      state <= S_JREG;
                    else                            state <= S_FETCH;
                end
                S_MEMADR: state <= is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state <= S_FETCH;
                S_EXEC:   state <= S_ALUWB;
                default:  state <= S_FETCH;
            endcase
        end
    end

    assign dbg_state = state;

    // Reset forces IDLE asynchronously, so every strobe decoded here drops with rstn
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        EXTOp    = 1'b0;
        ALUOp    = 5'd0;
        PCSrc    = 2'b00;
        GPRSel   = 2'b00;
        WDSel    = 2'b00;
        LOADSel  = 4'b0000;
        illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                EXTOp   = 1'b1;
                illegal = ~is_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                EXTOp   = 1'b1;
                ALUOp   = ALU_ADD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                GPRSel   = 2'b01;
                WDSel    = 2'b01;
                LOADSel  = is_lb ? 4'b0001 : 4'b0000;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (Op == OP_RTYPE) begin
                    ALUSrcB = 2'b00;
                    ALUOp   = r_alu;
                end else begin
                    ALUSrcB = 2'b10;
                    EXTOp   = (Op == OP_ADDI) || (Op == OP_SLTI);
                    ALUOp   = i_alu;
                end
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                GPRSel   = (Op == OP_RTYPE) ? 2'b00 : 2'b01;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_SUB;
                PCSrc   = 2'b01;
                PCWrite = is_bne ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSrc    = 2'b10;
                RegWrite = is_jal;
                GPRSel   = is_jal ? 2'b10 : 2'b00;
                WDSel    = is_jal ? 2'b10 : 2'b00;
            end
            S_JREG: begin
                PCWrite  = 1'b1;
                PCSrc    = 2'b11;
                RegWrite = is_jalr;
                WDSel    = is_jalr ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

endmodule
